// File: rtl/stream_demux_1to2.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_1to2
// Description : Registered 1-to-2 valid/ready stream demultiplexer. Each input
//               beat is routed by s_sel_i to output 0 or output 1. Each output
//               owns a single-entry register. With LOCK_PKT=1, the route taken
//               by the first beat of a packet is held until the beat flagged
//               last.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH     data width of the input and both outputs
//   LOCK_PKT  1: route latched per packet (first beat .. s_last_i)
//             0: route sampled on every beat, s_last_i only forwarded
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   s_data_i    input beat data
//   s_sel_i     route select (0 -> m0, 1 -> m1)
//   s_last_i    final beat of packet
//   s_valid_i   input beat present
//   s_ready_o   block accepts a beat this cycle (combinational)
//   m0_data_o   output 0 data           m1_data_o   output 1 data
//   m0_last_o   output 0 last flag      m1_last_o   output 1 last flag
//   m0_valid_o  output 0 beat present   m1_valid_o  output 1 beat present
//   m0_ready_i  output 0 consumer ready m1_ready_i  output 1 consumer ready
// ============================================================================
module stream_demux_1to2 #(
  parameter int WIDTH    = 8,
  parameter bit LOCK_PKT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic [WIDTH-1:0] s_data_i,
  input  logic             s_sel_i,
  input  logic             s_last_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,

  output logic [WIDTH-1:0] m0_data_o,
  output logic             m0_last_o,
  output logic             m0_valid_o,
  input  logic             m0_ready_i,

  output logic [WIDTH-1:0] m1_data_o,
  output logic             m1_last_o,
  output logic             m1_valid_o,
  input  logic             m1_ready_i
);

  // --------------------------------------------------------------------------
  // Packet-lock state
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t state_q;
  logic   lock_sel_q;

  // --------------------------------------------------------------------------
  // Output-register storage, index 0 -> m0, index 1 -> m1
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] data_q  [2];
  logic [WIDTH-1:0] data_d  [2];
  logic [1:0]       last_q;
  logic [1:0]       last_d;
  logic [1:0]       valid_q;
  logic [1:0]       valid_d;
  logic [1:0]       out_ready;
  logic [1:0]       load;

  logic             esel;
  logic             accept;

  assign out_ready = {m1_ready_i, m0_ready_i};

  // Inside a packet the latched route wins; between packets the live select
  // is used, so a select change on a stalled beat retargets it immediately.
  assign esel = (state_q == ST_LOCKED) ? lock_sel_q : s_sel_i;

  // Ready only looks at the selected output, so a stalled output never blocks
  // beats headed for the other one. The rst_n term keeps s_ready_o low while
  // reset is held, even though both registers are empty at that time.
  assign s_ready_o = rst_n & (~valid_q[esel] | out_ready[esel]);

  assign accept = s_valid_i & s_ready_o;

  assign load[0] = accept & ~esel;
  assign load[1] = accept &  esel;

  // --------------------------------------------------------------------------
  // Output register next-state: load has priority over drain so that a
  // simultaneous drain+reload keeps valid high and replaces the data.
  // Draining leaves data/last untouched, only valid falls.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      data_d[i]  = data_q[i];
      last_d[i]  = last_q[i];
      valid_d[i] = valid_q[i];
      if (load[i]) begin
        data_d[i]  = s_data_i;
        last_d[i]  = s_last_i;
        valid_d[i] = 1'b1;
      end else if (valid_q[i] && out_ready[i]) begin
        valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
      end
      last_q  <= '0;
      valid_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= data_d[i];
      end
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Packet-lock FSM. Only built when locking is enabled; otherwise the state
  // is tied to IDLE so esel always follows s_sel_i.
  // --------------------------------------------------------------------------
  generate
    if (LOCK_PKT) begin : g_lock
      state_t state_d;
      logic   lock_sel_d;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q    <= ST_IDLE;
          lock_sel_q <= 1'b0;
        end else begin
          state_q    <= state_d;
          lock_sel_q <= lock_sel_d;
        end
      end

      always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        case (state_q)
          ST_IDLE: begin
            // A single-beat packet (last on the first beat) never locks.
            if (accept && !s_last_i) begin
              state_d    = ST_LOCKED;
              lock_sel_d = s_sel_i;
            end
          end
          ST_LOCKED: begin
            // Gaps in s_valid_i keep the lock; only the last beat releases it.
            if (accept && s_last_i) begin
              state_d = ST_IDLE;
            end
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
    end else begin : g_nolock
      assign state_q    = ST_IDLE;
      assign lock_sel_q = 1'b0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Output mapping
  // --------------------------------------------------------------------------
  assign m0_data_o  = data_q[0];
  assign m0_last_o  = last_q[0];
  assign m0_valid_o = valid_q[0];

  assign m1_data_o  = data_q[1];
  assign m1_last_o  = last_q[1];
  assign m1_valid_o = valid_q[1];

endmodule
`default_nettype wire

// File: tb/tb_stream_demux_1to2.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_demux_1to2
// Description : Self-checking bench for stream_demux_1to2 (WIDTH=8,
//               LOCK_PKT=1). A queue-per-output reference model tracks which
//               beats are expected on each output and when the input may be
//               accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_demux_1to2;

  logic       clk;
  logic       rst_n;
  logic [7:0] s_data;
  logic       s_sel;
  logic       s_last;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] m0_data;
  logic       m0_last;
  logic       m0_valid;
  logic       m0_ready;
  logic [7:0] m1_data;
  logic       m1_last;
  logic       m1_valid;
  logic       m1_ready;

  int checks = 0;
  int errors = 0;

  // Reference model: each output holds at most one beat, stored as {last,data}.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  bit         in_pkt;
  bit         pkt_route;

  stream_demux_1to2 #(
    .WIDTH    (8),
    .LOCK_PKT (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_data_i   (s_data),
    .s_sel_i    (s_sel),
    .s_last_i   (s_last),
    .s_valid_i  (s_valid),
    .s_ready_o  (s_ready),
    .m0_data_o  (m0_data),
    .m0_last_o  (m0_last),
    .m0_valid_o (m0_valid),
    .m0_ready_i (m0_ready),
    .m1_data_o  (m1_data),
    .m1_last_o  (m1_last),
    .m1_valid_o (m1_valid),
    .m1_ready_i (m1_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle against the model,
  // then advance the model across the rising edge.
  task automatic step(input logic v, input logic sel, input logic last,
                      input logic [7:0] d, input logic r0, input logic r1);
    bit route;
    bit exp_rdy;
    bit acc;
    s_valid  = v;
    s_sel    = sel;
    s_last   = last;
    s_data   = d;
    m0_ready = r0;
    m1_ready = r1;
    @(negedge clk);
    check("m0_valid", 32'(m0_valid), 32'(q0.size() != 0));
    if (q0.size() != 0) begin
      check("m0_data", 32'(m0_data), 32'(q0[0][7:0]));
      check("m0_last", 32'(m0_last), 32'(q0[0][8]));
    end
    check("m1_valid", 32'(m1_valid), 32'(q1.size() != 0));
    if (q1.size() != 0) begin
      check("m1_data", 32'(m1_data), 32'(q1[0][7:0]));
      check("m1_last", 32'(m1_last), 32'(q1[0][8]));
    end
    route   = in_pkt ? pkt_route : sel;
    exp_rdy = route ? (q1.size() == 0 || r1) : (q0.size() == 0 || r0);
    check("s_ready", 32'(s_ready), 32'(exp_rdy));
    acc = v && exp_rdy;
    if (q0.size() != 0 && r0) void'(q0.pop_front());
    if (q1.size() != 0 && r1) void'(q1.pop_front());
    if (acc) begin
      if (route) q1.push_back({last, d});
      else       q0.push_back({last, d});
      if (!in_pkt && !last) begin
        in_pkt    = 1'b1;
        pkt_route = sel;
      end else if (in_pkt && last) begin
        in_pkt = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
  endtask

  // Assert reset away from any clock edge and check outputs clear at once.
  task automatic reset_mid_cycle();
    s_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_m0_valid", 32'(m0_valid), 32'd0);
    check("rst_m1_valid", 32'(m1_valid), 32'd0);
    check("rst_m0_data",  32'(m0_data),  32'd0);
    check("rst_m1_data",  32'(m1_data),  32'd0);
    check("rst_m0_last",  32'(m0_last),  32'd0);
    check("rst_m1_last",  32'(m1_last),  32'd0);
    check("rst_s_ready",  32'(s_ready),  32'd0);
    q0.delete();
    q1.delete();
    in_pkt    = 1'b0;
    pkt_route = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int m0_run;
    rst_n    = 1'b0;
    s_data   = '0;
    s_sel    = 1'b0;
    s_last   = 1'b0;
    s_valid  = 1'b0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    in_pkt    = 1'b0;
    pkt_route = 1'b0;

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    check("por_m0_valid", 32'(m0_valid), 32'd0);
    check("por_m1_valid", 32'(m1_valid), 32'd0);
    check("por_s_ready",  32'(s_ready),  32'd0);
    rst_n = 1'b1;

    // Basic routing: one beat to each output
    step(1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
    idle_cycles(2);

    // Back-pressure isolation: m1 stalled and full, m0 still flows
    step(1'b1, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'h66, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'h66, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    idle_cycles(2);

    // Packet lock: select toggles and a 2-cycle gap inside the packet
    step(1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h02, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h03, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 8'h04, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 8'h77, 1'b1, 1'b1);
    idle_cycles(2);

    // Full throughput: 16 beats back to back into m0
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'(i == 15), 8'(8'h20 + i), 1'b1, 1'b1);
    m0_run = 0;
    while (m0_valid && m0_run < 20) begin
      m0_run++;
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    end
    check("m0_tail_after_stream", 32'(m0_run), 32'd1);
    idle_cycles(1);

    // Reset mid-packet with both outputs full
    step(1'b1, 1'b0, 1'b1, 8'hC0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'hB1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'hB2, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    reset_mid_cycle();
    step(1'b1, 1'b0, 1'b0, 8'hD0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 8'hD1, 1'b1, 1'b1);
    idle_cycles(2);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) == 0), 8'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
    end
    idle_cycles(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_demux_1to2.md
Name: stream_demux_1to2

Overview:
- Registered 1-to-2 stream demultiplexer; the reverse direction of the team's 2:1 mux.
- Routes a valid/ready input stream to one of two output streams, chosen by a select bit.
- Each output has a single-entry output register.
- Optional packet lock: the route chosen on the first beat holds until the beat flagged last.
- Sits between a shared source (e.g. UART RX byte stream) and two consumers on the Basys3 fabric.

Parameters:
- WIDTH, 8: data width of input and both outputs.
- LOCK_PKT, 1: 1 = select latched per packet (first beat to s_last); 0 = select sampled every beat.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_data  input  WIDTH  input beat data.
- s_sel  input  1  route select: 0 -> m0, 1 -> m1.
- s_last  input  1  final beat of packet.
- s_valid  input  1  input beat present.
- s_ready  output  1  block accepts beat this cycle.
- m0_data  output  WIDTH  output 0 data.
- m0_last  output  1  output 0 last flag.
- m0_valid  output  1  output 0 beat present.
- m0_ready  input  1  output 0 consumer ready.
- m1_data, m1_last, m1_valid, m1_ready: same as the m0 ports, for output 1.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). While rst_n=0:
  - m0/m1 valid, data and last are all 0.
  - FSM is IDLE and lock_sel is 0.
  - s_ready is 0.
- Effective select: esel = s_sel in IDLE; esel = lock_sel in LOCKED.
- s_ready is combinational: s_ready = !mX_valid || mX_ready, where X = esel. It never depends on s_valid.
- Accept occurs when s_valid && s_ready. On the next rising edge:
  - mX_data <= s_data, mX_last <= s_last, mX_valid <= 1.
  - The non-selected output is untouched.
- Latency: exactly 1 cycle from accept to the beat appearing on mX.
- Throughput: 1 beat/cycle per output when it drains continuously.
  - If mX drains and reloads in the same cycle, mX_valid stays 1 and data updates.
- Drain: when mX_valid && mX_ready and no load into X that cycle, mX_valid <= 0 and data holds its last value.
- Output stability: while mX_valid=1 and mX_ready=0, mX_data and mX_last are held constant.
- No head-of-line blocking across outputs in IDLE: a stalled m1 does not block beats selected for m0.
- FSM (LOCK_PKT=1):
  - IDLE, accept with s_last=0 -> LOCKED; lock_sel <= s_sel.
  - IDLE, accept with s_last=1 -> stay IDLE (single-beat packet).
  - LOCKED: s_sel is ignored; accept with s_last=1 -> IDLE.
  - LOCKED, no accept -> stay LOCKED, including while s_valid=0 (gaps within a packet are allowed).
- LOCK_PKT=0: FSM is held in IDLE; s_last is only forwarded.
- Select change while s_valid=1 and not yet accepted, in IDLE: legal. The new select takes effect immediately and s_ready re-evaluates for the new target.
- Reset mid-packet or with full output registers: contents are discarded immediately and the block returns to IDLE. No partial state survives.
- Reset release: s_ready may assert in the first cycle after rst_n rises, since both outputs are empty.

Test Plan:
- Reset check: assert rst_n=0 asynchronously mid-cycle with both outputs full -> m0_valid=m1_valid=0, data=0, s_ready=0 immediately; after release, s_ready=1.
- Basic routing: beats 0xA5 (sel=0, last=1) then 0x3C (sel=1, last=1), both readies=1 -> m0 shows 0xA5 one cycle after accept, m1 shows 0x3C one cycle later, and each valid is high for exactly 1 cycle.
- Back-pressure isolation: m1_ready=0 with m1 full; send sel=1 beat -> s_ready=0 and the beat is held. Switch to a sel=0 beat 0x11 -> accepted; m0 shows 0x11 and m1_data is unchanged.
- Packet lock: LOCK_PKT=1; send 4-beat packet 0x01..0x04 with sel=1 on the first beat, then toggle s_sel each beat and insert a 2-cycle s_valid gap -> all 4 beats go to m1 and m1_last=1 only on 0x04. The next beat with sel=0 goes to m0.
- Full throughput: stream 16 beats, sel=0, m0_ready=1 -> s_ready stays 1, m0_valid is high for 16 consecutive cycles, and data arrives in order.
- Reset mid-packet: after 2 beats of a locked packet to m1, pulse rst_n low -> IDLE. A following sel=0 first beat routes to m0.
